// File: rtl/mult_error_monitor.sv
// mult_error_monitor
// Measures how far an approximate 8x8 multiplier strays from the exact
// product over a run of SAMPLES operand/product samples.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse: begins a run from IDLE or DONE
//   in_valid/ready  sample handshake; ready only while running
//   A, B, P         operands and the approximate product under test
//   busy            run in progress (RUN or DRAIN)
//   done            results valid; held until the next start or reset
//   err_count       samples with P != A*B (saturating at 65535)
//   sum_abs_err     sum of |A*B - P| (saturating at 2^ACC_W-1)
//   max_abs_err     largest |A*B - P| in the run
//   sum_err         (MULT_ERR_BIAS_EN only) signed sum of A*B - P, saturating
//
// Optional feature macro: MULT_ERR_BIAS_EN adds the sum_err bias output.
module mult_error_monitor #(
   parameter int unsigned SAMPLES = 256,
   parameter int unsigned ACC_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       A,
   input  logic [7:0]       B,
   input  logic [15:0]      P,
   output logic             busy,
   output logic             done,
   output logic [15:0]      err_count,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [15:0]      max_abs_err
`ifdef MULT_ERR_BIAS_EN
   ,
   output logic signed [ACC_W:0] sum_err
`endif
);

   localparam int unsigned CNT_W    = 16;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       drain_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             done_q;

   logic             accept_c;
   logic             run_start_c;

   assign accept_c    = in_valid & in_ready_q;
   assign run_start_c = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   // Run control FSM; in_ready/busy/done are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         drain_q    <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (accept_c) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_IDX) begin
                     state_q    <= ST_DRAIN;
                     drain_q    <= '0;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // Three cycles: the last sample leaves S3 before done rises.
               drain_q <= drain_q + 2'd1;
               if (drain_q == 2'd2) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // S1 / S2 valid pipe
   logic v1_q;
   logic v2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= accept_c;
         v2_q <= v1_q;
      end
   end

   // S1 operand capture
   logic [7:0]  a1_q;
   logic [7:0]  b1_q;
   logic [15:0] p1_q;

   always_ff @(posedge clk) begin
      if (accept_c) begin
         a1_q <= A;
         b1_q <= B;
         p1_q <= P;
      end
   end

   // S2: exact product and error; 17-bit difference so |error| fits 16 bits
   logic [15:0] prod_c;
   logic [16:0] diff_c;
   logic [15:0] abs_c;
   logic [15:0] abs2_q;

   assign prod_c = 16'(a1_q) * 16'(b1_q);
   assign diff_c = {1'b0, prod_c} - {1'b0, p1_q};
   assign abs_c  = diff_c[16] ? 16'(17'd0 - diff_c) : diff_c[15:0];

`ifdef MULT_ERR_BIAS_EN
   logic [16:0] err2_q;
`endif

   always_ff @(posedge clk) begin
      abs2_q <= abs_c;
`ifdef MULT_ERR_BIAS_EN
      err2_q <= diff_c;
`endif
   end

   // S3: saturating accumulators
   logic [CNT_W-1:0] err_cnt_q;
   logic [ACC_W-1:0] sum_abs_q;
   logic [15:0]      max_abs_q;
   logic [ACC_W:0]   sum_ext_c;
   logic [ACC_W-1:0] sum_nxt_c;

   assign sum_ext_c = {1'b0, sum_abs_q} + (ACC_W+1)'(abs2_q);
   assign sum_nxt_c = sum_ext_c[ACC_W] ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];

`ifdef MULT_ERR_BIAS_EN
   logic [ACC_W:0]   sum_err_q;
   logic [ACC_W+1:0] serr_ext_c;
   logic [ACC_W:0]   serr_nxt_c;

   // One guard bit; disagreeing top bits mean the signed range was left.
   assign serr_ext_c = {sum_err_q[ACC_W], sum_err_q} + {{(ACC_W-15){err2_q[16]}}, err2_q};

   always_comb begin
      serr_nxt_c = serr_ext_c[ACC_W:0];
      if (serr_ext_c[ACC_W+1] != serr_ext_c[ACC_W]) begin
         serr_nxt_c = serr_ext_c[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst || run_start_c) begin
         err_cnt_q <= '0;
         sum_abs_q <= '0;
         max_abs_q <= '0;
`ifdef MULT_ERR_BIAS_EN
         sum_err_q <= '0;
`endif
      end else if (v2_q) begin
         sum_abs_q <= sum_nxt_c;
         if ((abs2_q != 16'd0) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
         if (abs2_q > max_abs_q) begin
            max_abs_q <= abs2_q;
         end
`ifdef MULT_ERR_BIAS_EN
         sum_err_q <= serr_nxt_c;
`endif
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_count   = err_cnt_q;
   assign sum_abs_err = sum_abs_q;
   assign max_abs_err = max_abs_q;
`ifdef MULT_ERR_BIAS_EN
   assign sum_err     = sum_err_q;
`endif

endmodule

// File: tb/tb_mult_error_monitor.sv
// Bench for mult_error_monitor: table of 4-sample runs with hand-derived
// results, hand sequences for latency / handshake / reset corners, random
// runs against a queue-based model, and a saturation run on a narrow
// accumulator instance.
module tb_mult_error_monitor;

   localparam int unsigned N0 = 4;
   localparam int unsigned W0 = 32;
   localparam int unsigned N1 = 300;
   localparam int unsigned W1 = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        sel = 1'b0;
   logic [7:0]  op_a = '0;
   logic [7:0]  op_b = '0;
   logic [15:0] op_p = '0;

   logic start0, start1, valid0, valid1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign valid0 = in_valid & ~sel;
   assign valid1 = in_valid & sel;

   logic          rdy0, rdy1, busy0, busy1, done0, done1;
   logic [15:0]   cnt0, cnt1, max0, max1;
   logic [W0-1:0] sum0;
   logic [W1-1:0] sum1;
`ifdef MULT_ERR_BIAS_EN
   logic signed [W0:0] serr0;
   logic signed [W1:0] serr1;
`endif

   mult_error_monitor #(.SAMPLES(N0), .ACC_W(W0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .in_valid(valid0), .in_ready(rdy0),
      .A(op_a), .B(op_b), .P(op_p), .busy(busy0), .done(done0),
      .err_count(cnt0), .sum_abs_err(sum0), .max_abs_err(max0)
`ifdef MULT_ERR_BIAS_EN
      , .sum_err(serr0)
`endif
   );

   mult_error_monitor #(.SAMPLES(N1), .ACC_W(W1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(valid1), .in_ready(rdy1),
      .A(op_a), .B(op_b), .P(op_p), .busy(busy1), .done(done1),
      .err_count(cnt1), .sum_abs_err(sum1), .max_abs_err(max1)
`ifdef MULT_ERR_BIAS_EN
      , .sum_err(serr1)
`endif
   );

   // Outputs of whichever instance is under test
   logic        rdy, busy, done;
   logic [15:0] cnt, mx;
   logic [63:0] sum_m;
   logic [63:0] serr_m;
   always_comb begin
      rdy   = sel ? rdy1  : rdy0;
      busy  = sel ? busy1 : busy0;
      done  = sel ? done1 : done0;
      cnt   = sel ? cnt1  : cnt0;
      mx    = sel ? max1  : max0;
      sum_m = sel ? 64'(sum1) : 64'(sum0);
`ifdef MULT_ERR_BIAS_EN
      serr_m = sel ? 64'(serr1) : 64'(serr0);
`else
      serr_m = '0;
`endif
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit  m_run   = 1'b0;
   int  m_cnt   = 0;
   int  m_drain = 0;
   bit  m_done  = 1'b0;
   int  q_abs[$];
   int  q_serr[$];

   function automatic int model_n();
      return sel ? int'(N1) : int'(N0);
   endfunction

   function automatic int model_w();
      return sel ? int'(W1) : int'(W0);
   endfunction

   function automatic longint exp_sum();
      longint s = 0;
      longint lim = (64'sd1 <<< model_w()) - 1;
      foreach (q_abs[i]) s += q_abs[i];
      return (s > lim) ? lim : s;
   endfunction

   function automatic longint exp_cnt();
      int c = 0;
      foreach (q_abs[i]) if (q_abs[i] != 0) c++;
      return (c > 65535) ? 65535 : c;
   endfunction

   function automatic longint exp_max();
      int m = 0;
      foreach (q_abs[i]) if (q_abs[i] > m) m = q_abs[i];
      return m;
   endfunction

   function automatic longint exp_serr();
      longint s = 0;
      longint hi = (64'sd1 <<< model_w()) - 1;
      longint lo = -(64'sd1 <<< model_w());
      foreach (q_serr[i]) begin
         s += q_serr[i];
         if (s > hi) s = hi;
         if (s < lo) s = lo;
      end
      return s;
   endfunction

   // Apply the run rules to the inputs present at this edge.
   task automatic model_edge();
      int e;
      if (rst) begin
         m_run = 1'b0; m_drain = 0; m_done = 1'b0;
         q_abs.delete(); q_serr.delete();
      end else if (start && !m_run && m_drain == 0) begin
         m_run = 1'b1; m_cnt = 0; m_done = 1'b0;
         q_abs.delete(); q_serr.delete();
      end else if (m_run && in_valid) begin
         e = int'(op_a) * int'(op_b) - int'(op_p);
         q_serr.push_back(e);
         q_abs.push_back(e < 0 ? -e : e);
         m_cnt++;
         if (m_cnt == model_n()) begin
            m_run = 1'b0;
            m_drain = 3;
         end
      end else if (m_drain > 0) begin
         m_drain--;
         if (m_drain == 0) m_done = 1'b1;
      end
   endtask

   task automatic check_cycle();
      chk("in_ready", rdy, m_run);
      chk("busy", busy, m_run || m_drain > 0);
      chk("done", done, m_done);
      if (!m_run && m_drain == 0) begin
         chk("err_count", cnt, exp_cnt());
         chk("sum_abs_err", sum_m, exp_sum());
         chk("max_abs_err", mx, exp_max());
`ifdef MULT_ERR_BIAS_EN
         chk("sum_err", serr_m, exp_serr());
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_cycle();
   endtask

   function automatic logic [15:0] gen_p(input logic [7:0] x, input logic [7:0] y);
      int pr = int'(x) * int'(y);
      int d;
      case ($urandom_range(0, 2))
         0: return 16'(pr);
         1: begin
            d = pr + int'($urandom_range(0, 16)) - 8;
            if (d < 0) d = 0;
            if (d > 65535) d = 65535;
            return 16'(d);
         end
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic run_random(input int prob);
      int guard = 0;
      start = 1'b1; tick(); start = 1'b0;
      while ((m_run || m_drain > 0) && guard < 4000) begin
         in_valid = ($urandom_range(0, 99) < prob);
         op_a = 8'($urandom);
         op_b = 8'($urandom);
         op_p = gen_p(op_a, op_b);
         start = ($urandom_range(0, 15) == 0);
         tick();
         guard++;
      end
      start = 1'b0; in_valid = 1'b0;
      repeat (2) tick();
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } samp_t;

   typedef struct packed {
      samp_t [3:0] s;
      int          cnt;
      longint      sum;
      int          mx;
      longint      serr;
   } run_t;

   function automatic samp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      samp_t t;
      t.a = a; t.b = b; t.p = p;
      return t;
   endfunction

   run_t tbl [5];

   initial begin
      tbl[0].s[0] = mk(3, 5, 15);  tbl[0].s[1] = mk(3, 5, 15);
      tbl[0].s[2] = mk(3, 5, 15);  tbl[0].s[3] = mk(3, 5, 15);
      tbl[0].cnt = 0; tbl[0].sum = 0; tbl[0].mx = 0; tbl[0].serr = 0;

      tbl[1].s[0] = mk(255, 255, 16'hFE00); tbl[1].s[1] = mk(16, 16, 16'h0104);
      tbl[1].s[2] = mk(2, 3, 6);            tbl[1].s[3] = mk(0, 0, 0);
      tbl[1].cnt = 2; tbl[1].sum = 5; tbl[1].mx = 4; tbl[1].serr = -3;

      tbl[2].s[0] = mk(255, 255, 0);        tbl[2].s[1] = mk(0, 0, 16'hFFFF);
      tbl[2].s[2] = mk(100, 100, 10001);    tbl[2].s[3] = mk(7, 7, 49);
      tbl[2].cnt = 3; tbl[2].sum = 130561; tbl[2].mx = 65535; tbl[2].serr = -511;

      tbl[3].s[0] = mk(1, 1, 6);            tbl[3].s[1] = mk(10, 10, 90);
      tbl[3].s[2] = mk(1, 1, 6);            tbl[3].s[3] = mk(2, 2, 1);
      tbl[3].cnt = 4; tbl[3].sum = 23; tbl[3].mx = 10; tbl[3].serr = 3;

      tbl[4].s[0] = mk(255, 1, 255);        tbl[4].s[1] = mk(1, 255, 255);
      tbl[4].s[2] = mk(128, 2, 256);        tbl[4].s[3] = mk(0, 255, 0);
      tbl[4].cnt = 0; tbl[4].sum = 0; tbl[4].mx = 0; tbl[4].serr = 0;

      // Reset state
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_in_ready", rdy, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err_count", cnt, 0);
      chk("reset_sum", sum_m, 0);
      chk("reset_max", mx, 0);

      // Reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_prio_busy", busy, 0);
      chk("rst_prio_ready", rdy, 0);
      tick();

      // Table runs with back-to-back samples; done exactly 7 edges after start
      for (int r = 0; r < 5; r++) begin
         start = 1'b1; tick(); start = 1'b0;
         for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            op_a = tbl[r].s[k].a; op_b = tbl[r].s[k].b; op_p = tbl[r].s[k].p;
            tick();
         end
         in_valid = 1'b0;
         tick(); tick();
         chk("tbl_done_early", done, 0);
         tick();
         chk("tbl_done", done, 1);
         chk("tbl_err_count", cnt, 64'(tbl[r].cnt));
         chk("tbl_sum_abs_err", sum_m, 64'(tbl[r].sum));
         chk("tbl_max_abs_err", mx, 64'(tbl[r].mx));
`ifdef MULT_ERR_BIAS_EN
         chk("tbl_sum_err", serr_m, 64'(tbl[r].serr));
`endif
         repeat (2) tick();
      end

      // Accumulator latency: visible on the third edge after acceptance
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1; op_a = 8'd1; op_b = 8'd1; op_p = 16'd2;
      tick();
      in_valid = 1'b0;
      chk("lat_edge1", cnt, 0);
      tick();
      chk("lat_edge2", cnt, 0);
      tick();
      chk("lat_edge3", cnt, 1);
      in_valid = 1'b1; op_a = 8'd2; op_b = 8'd2; op_p = 16'd4;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (4) tick();

      // in_valid every other cycle: four acceptances, ready drops right after
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_valid = (i % 2 == 0);
         op_a = 8'(i + 1); op_b = 8'd3; op_p = 16'd0;
         tick();
         if (i == 5) chk("toggle_ready_before", rdy, 1);
         if (i == 6) chk("toggle_ready_drop", rdy, 0);
      end
      in_valid = 1'b0;
      chk("toggle_err_count", cnt, 4);
      chk("toggle_sum", sum_m, 48);
      chk("toggle_done", done, 1);

      // Reset two cycles after the third acceptance discards the run
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1; op_a = 8'd10; op_b = 8'd10; op_p = 16'd0;
      repeat (3) tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", rdy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err_count", cnt, 0);
      chk("midrst_sum", sum_m, 0);
      chk("midrst_max", mx, 0);
      tick();
      chk("midrst_inflight_count", cnt, 0);
      chk("midrst_inflight_sum", sum_m, 0);
      run_random(100);

      // Random runs, with stray start pulses during RUN/DRAIN
      for (int r = 0; r < 12; r++) begin
         run_random(int'($urandom_range(30, 100)));
      end

      // Narrow accumulator saturates
      rst = 1'b1; sel = 1'b1; tick(); rst = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1; op_a = 8'd255; op_b = 8'd255; op_p = 16'd0;
      repeat (300) tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("sat_done", done, 1);
      chk("sat_sum", sum_m, 64'hFF_FFFF);
      chk("sat_err_count", cnt, 300);
      chk("sat_max", mx, 65025);
      run_random(80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
